// File: rtl/lcd_screen_arbiter_if.sv
// lcd_screen_arbiter_if: write-request bus, clear control and screen image of the LCD screen arbiter.
// master = producer/LCD side, slave = arbiter.
interface lcd_screen_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   REQ;
  logic [5*NREQ-1:0] WR_ADDR;
  logic [8*NREQ-1:0] WR_CHAR;
  logic [NREQ-1:0]   ACK;
  logic              CLEAR_REQ;
  logic              BUSY;
  logic [255:0]      DISPLAY_DATA;

  modport master (
    output REQ, WR_ADDR, WR_CHAR, CLEAR_REQ,
    input  ACK, BUSY, DISPLAY_DATA
  );

  modport slave (
    input  REQ, WR_ADDR, WR_CHAR, CLEAR_REQ,
    output ACK, BUSY, DISPLAY_DATA
  );
endinterface

// File: rtl/lcd_screen_arbiter.sv
// lcd_screen_arbiter: owns the 32-cell LCD character buffer. Producers write one cell
// per cycle through a REQ/ACK port arbitrated round-robin; CLEAR_REQ blanks the whole
// screen one cell per cycle (32 cycles) and wins over any pending write.
// Build option: define LCD_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins,
// no rotating pointer). Mask, clear and timing are identical in both builds.
module lcd_screen_arbiter #(
  parameter int         NREQ       = 3,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input logic                 CLK,
  input logic                 RESETN,
  lcd_screen_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [31:0][7:0] cell_q, cell_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [NREQ-1:0]  elig, gnt_oh;
  logic             gnt_vld;
  logic [4:0]       gnt_addr;
  logic [7:0]       gnt_char;
`ifndef LCD_ARB_FIXED_PRIO_EN
  logic [PW-1:0]    ptr_q, ptr_d, gnt_nxt;

  // distance of requester i from the pointer, walking upward with wrap
  function automatic int rr_dist(input int i, input logic [PW-1:0] p);
    return (i >= int'(p)) ? (i - int'(p)) : (i - int'(p) + NREQ);
  endfunction
`endif

  // a requester acked this cycle is still holding REQ; mask it to avoid a double write
  assign elig = bus.REQ & ~ack_q;

  // pick the winning requester and mux its address/character
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_oh   = '0;
    gnt_addr = '0;
    gnt_char = '0;
`ifdef LCD_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_vld && elig[i]) begin
        gnt_vld   = 1'b1;
        gnt_oh[i] = 1'b1;
        gnt_addr  = bus.WR_ADDR[5*i +: 5];
        gnt_char  = bus.WR_CHAR[8*i +: 8];
      end
    end
`else
    gnt_nxt = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!gnt_vld && elig[i] && rr_dist(i, ptr_q) == k) begin
          gnt_vld   = 1'b1;
          gnt_oh[i] = 1'b1;
          gnt_addr  = bus.WR_ADDR[5*i +: 5];
          gnt_char  = bus.WR_CHAR[8*i +: 8];
          gnt_nxt   = (i == NREQ - 1) ? '0 : PW'(i + 1);
        end
      end
    end
`endif
  end

  // next state: clear beats writes; during clear blank cell CNT each cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cell_d  = cell_q;
    ack_d   = '0;
`ifndef LCD_ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.CLEAR_REQ) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (gnt_vld) begin
          cell_d[gnt_addr] = gnt_char;
          ack_d            = gnt_oh;
`ifndef LCD_ARB_FIXED_PRIO_EN
          ptr_d            = gnt_nxt;
`endif
        end
      end
      CLEAR: begin
        cell_d[cnt_q] = BLANK_CHAR;
        cnt_d         = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers; async reset blanks the screen immediately
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cell_q  <= {32{BLANK_CHAR}};
      ack_q   <= '0;
`ifndef LCD_ARB_FIXED_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cell_q  <= cell_d;
      ack_q   <= ack_d;
`ifndef LCD_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign bus.ACK          = ack_q;
  assign bus.BUSY         = (state_q == CLEAR);
  assign bus.DISPLAY_DATA = cell_q;
endmodule

// File: tb/tb_lcd_screen_arbiter.sv
// tb_lcd_screen_arbiter: directed scenarios plus randomized producers, checked against a
// behavioural screen model (cell array, grant scan, clear countdown).
module tb_lcd_screen_arbiter;
  localparam int N = 3;
  localparam logic [7:0] BL = 8'h20;

  logic CLK;
  logic RESETN;
  int   n_cmp = 0;
  int   n_err = 0;

  lcd_screen_arbiter_if #(.NREQ(N)) bus ();

  lcd_screen_arbiter #(.NREQ(N), .BLANK_CHAR(BL)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [7:0] m_cell [32];
  logic [N-1:0] m_ack;
  int m_ptr;
  int m_clr_left;   // cycles of clear still to run; 0 means idle

  function automatic void model_reset();
    for (int k = 0; k < 32; k++) m_cell[k] = BL;
    m_ack = '0;
    m_ptr = 0;
    m_clr_left = 0;
  endfunction

  // advance the model by one clock edge using the inputs currently driven
  function automatic void model_update();
    int g;
    int i;
    g = -1;
    if (m_clr_left > 0) begin
      m_cell[32 - m_clr_left] = BL;
      m_clr_left--;
      m_ack = '0;
    end else if (bus.CLEAR_REQ) begin
      m_clr_left = 32;
      m_ack = '0;
    end else begin
      for (int k = 0; k < N; k++) begin
`ifdef LCD_ARB_FIXED_PRIO_EN
        i = k;
`else
        i = (m_ptr + k) % N;
`endif
        if (g < 0 && bus.REQ[i] && !m_ack[i]) g = i;
      end
      m_ack = '0;
      if (g >= 0) begin
        m_cell[bus.WR_ADDR[5*g +: 5]] = bus.WR_CHAR[8*g +: 8];
        m_ack[g] = 1'b1;
        m_ptr = (g + 1) % N;
      end
    end
  endfunction

  function automatic logic [255:0] exp_disp();
    logic [255:0] d;
    for (int k = 0; k < 32; k++) d[8*k +: 8] = m_cell[k];
    return d;
  endfunction

  task automatic step();
    model_update();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    RESETN = 1'b0;
    bus.REQ = '0;
    bus.CLEAR_REQ = 1'b0;
    model_reset();
    @(posedge CLK);
    #2;
    RESETN = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.REQ = '0; bus.WR_ADDR = '0; bus.WR_CHAR = '0; bus.CLEAR_REQ = 1'b0;
    RESETN = 1'b1;
    #1 RESETN = 1'b0;
    model_reset();
    #2;
    n_cmp++;
    if (bus.DISPLAY_DATA !== {32{BL}}) begin
      n_err++; $display("FAIL reset_async_disp: got %h want %h", bus.DISPLAY_DATA, {32{BL}});
    end
    @(posedge CLK); #2;
    RESETN = 1'b1;
    for (int c = 0; c < 5; c++) step();
    n_cmp++;
    if (bus.DISPLAY_DATA !== {32{BL}}) begin
      n_err++; $display("FAIL reset_idle_disp: got %h want %h", bus.DISPLAY_DATA, {32{BL}});
    end
    n_cmp++;
    if (bus.ACK !== 3'b000 || bus.BUSY !== 1'b0) begin
      n_err++; $display("FAIL reset_idle_ctl: ack=%b busy=%b want ack=000 busy=0", bus.ACK, bus.BUSY);
    end
  endtask

  task automatic test_single_write();
    bus.REQ = 3'b001;
    bus.WR_ADDR[4:0] = 5'd5;
    bus.WR_CHAR[7:0] = 8'h41;
    step();
    n_cmp++;
    if (bus.ACK !== 3'b001) begin
      n_err++; $display("FAIL single_ack: got %b want 001", bus.ACK);
    end
    n_cmp++;
    if (bus.DISPLAY_DATA !== exp_disp() || bus.DISPLAY_DATA[47:40] !== 8'h41) begin
      n_err++; $display("FAIL single_disp: got %h want %h", bus.DISPLAY_DATA, exp_disp());
    end
    bus.REQ = 3'b000;
    step();
    n_cmp++;
    if (bus.ACK !== 3'b000) begin
      n_err++; $display("FAIL single_ack_pulse: got %b want 000", bus.ACK);
    end
  endtask

  task automatic test_round_robin();
    int exp_seq [6];
    logic [N-1:0] prev;
`ifdef LCD_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 1, 0, 1, 0, 1};
`else
    exp_seq = '{0, 1, 2, 0, 1, 2};
`endif
    do_reset();
    bus.WR_ADDR = {5'd12, 5'd11, 5'd10};
    bus.WR_CHAR = {8'h63, 8'h62, 8'h61};
    bus.REQ = 3'b111;
    prev = '0;
    for (int c = 0; c < 6; c++) begin
      step();
      n_cmp++;
      if (bus.ACK !== N'(1 << exp_seq[c])) begin
        n_err++; $display("FAIL rr_order[%0d]: got %b want grant %0d", c, bus.ACK, exp_seq[c]);
      end
      n_cmp++;
      if ((bus.ACK & prev) !== '0) begin
        n_err++; $display("FAIL rr_double_ack[%0d]: got %b after %b want no overlap", c, bus.ACK, prev);
      end
      prev = bus.ACK;
    end
    n_cmp++;
    if (bus.DISPLAY_DATA !== exp_disp()) begin
      n_err++; $display("FAIL rr_disp: got %h want %h", bus.DISPLAY_DATA, exp_disp());
    end
    bus.REQ = '0;
    step();
  endtask

  task automatic test_clear();
    int a;
    int guard;
    int busy_cnt;
    a = 0; guard = 0;
    bus.REQ = 3'b001;
    bus.WR_ADDR[4:0] = 5'd0;
    bus.WR_CHAR[7:0] = 8'h30;
    while (a < 32 && guard < 200) begin
      step();
      guard++;
      if (bus.ACK[0]) begin
        a++;
        bus.WR_ADDR[4:0] = 5'(a);
      end
    end
    bus.REQ = '0;
    n_cmp++;
    if (a != 32) begin
      n_err++; $display("FAIL fill_timeout: got %0d writes want 32", a);
    end
    n_cmp++;
    if (bus.DISPLAY_DATA !== {32{8'h30}}) begin
      n_err++; $display("FAIL fill_disp: got %h want all 30", bus.DISPLAY_DATA);
    end
    bus.CLEAR_REQ = 1'b1;
    bus.REQ = 3'b010;
    bus.WR_ADDR[9:5] = 5'd7;
    bus.WR_CHAR[15:8] = 8'h5A;
    step();
    bus.CLEAR_REQ = 1'b0;
    n_cmp++;
    if (bus.ACK !== 3'b000 || bus.BUSY !== 1'b1) begin
      n_err++; $display("FAIL clear_start: ack=%b busy=%b want ack=000 busy=1", bus.ACK, bus.BUSY);
    end
    busy_cnt = 1;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (bus.BUSY === 1'b1) busy_cnt++;
      n_cmp++;
      if (bus.DISPLAY_DATA[8*(k-1) +: 8] !== BL ||
          (k < 32 && bus.DISPLAY_DATA[8*k +: 8] !== 8'h30) || bus.ACK !== 3'b000) begin
        n_err++; $display("FAIL clear_order[%0d]: cell=%h next=%h ack=%b want 20/30/000",
                          k, bus.DISPLAY_DATA[8*(k-1) +: 8], bus.DISPLAY_DATA[8*(k%32) +: 8], bus.ACK);
      end
    end
    n_cmp++;
    if (busy_cnt != 32) begin
      n_err++; $display("FAIL clear_busy_len: got %0d want 32", busy_cnt);
    end
    n_cmp++;
    if (bus.DISPLAY_DATA !== {32{BL}}) begin
      n_err++; $display("FAIL clear_disp: got %h want all 20", bus.DISPLAY_DATA);
    end
    step();
    n_cmp++;
    if (bus.ACK !== 3'b010 || bus.DISPLAY_DATA[63:56] !== 8'h5A) begin
      n_err++; $display("FAIL clear_then_ack: ack=%b cell7=%h want 010/5a", bus.ACK, bus.DISPLAY_DATA[63:56]);
    end
    bus.REQ = '0;
    step();
  endtask

  task automatic test_reset_mid_clear();
    bus.REQ = 3'b100;
    bus.WR_ADDR[14:10] = 5'd25;
    bus.WR_CHAR[23:16] = 8'h58;
    step();
    bus.REQ = '0;
    bus.CLEAR_REQ = 1'b1;
    step();
    bus.CLEAR_REQ = 1'b0;
    for (int c = 0; c < 10; c++) step();
    n_cmp++;
    if (bus.BUSY !== 1'b1 || bus.DISPLAY_DATA[207:200] !== 8'h58) begin
      n_err++; $display("FAIL midclr_pre: busy=%b cell25=%h want 1/58", bus.BUSY, bus.DISPLAY_DATA[207:200]);
    end
    RESETN = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (bus.BUSY !== 1'b0 || bus.DISPLAY_DATA !== {32{BL}} || bus.ACK !== 3'b000) begin
      n_err++; $display("FAIL midclr_async: busy=%b ack=%b disp=%h want 0/000/all 20",
                        bus.BUSY, bus.ACK, bus.DISPLAY_DATA);
    end
    @(posedge CLK); #2;
    RESETN = 1'b1;
    bus.WR_ADDR = {5'd3, 5'd2, 5'd1};
    bus.WR_CHAR = {8'h43, 8'h42, 8'h41};
    bus.REQ = 3'b111;
    step();
    n_cmp++;
    if (bus.ACK !== 3'b001 || bus.BUSY !== 1'b0) begin
      n_err++; $display("FAIL midclr_ptr0: ack=%b busy=%b want 001/0", bus.ACK, bus.BUSY);
    end
    step();
    n_cmp++;
    if (bus.ACK !== 3'b010) begin
      n_err++; $display("FAIL midclr_second: got %b want 010", bus.ACK);
    end
    bus.REQ = '0;
    step();
  endtask

  task automatic test_same_cell();
    do_reset();
    bus.WR_ADDR = {5'd31, 5'd0, 5'd31};
    bus.WR_CHAR = {8'h32, 8'h00, 8'h31};
    bus.REQ = 3'b101;
    step();
    n_cmp++;
    if (bus.ACK !== 3'b001 || bus.DISPLAY_DATA[255:248] !== 8'h31) begin
      n_err++; $display("FAIL same_first: ack=%b cell31=%h want 001/31", bus.ACK, bus.DISPLAY_DATA[255:248]);
    end
    bus.REQ[0] = 1'b0;
    step();
    n_cmp++;
    if (bus.ACK !== 3'b100 || bus.DISPLAY_DATA[255:248] !== 8'h32) begin
      n_err++; $display("FAIL same_last: ack=%b cell31=%h want 100/32", bus.ACK, bus.DISPLAY_DATA[255:248]);
    end
    bus.REQ = '0;
    step();
    n_cmp++;
    if (bus.DISPLAY_DATA !== exp_disp()) begin
      n_err++; $display("FAIL same_disp: got %h want %h", bus.DISPLAY_DATA, exp_disp());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      bus.CLEAR_REQ = ($urandom_range(0, 59) == 0);
      step();
      n_cmp++;
      if (bus.ACK !== m_ack || bus.BUSY !== 1'(m_clr_left > 0)) begin
        n_err++; $display("FAIL rand_ctl[%0d]: ack=%b busy=%b want ack=%b busy=%0d",
                          c, bus.ACK, bus.BUSY, m_ack, m_clr_left > 0);
      end
      n_cmp++;
      if (bus.DISPLAY_DATA !== exp_disp()) begin
        n_err++; $display("FAIL rand_disp[%0d]: got %h want %h", c, bus.DISPLAY_DATA, exp_disp());
      end
      // producers change their request only when idle or just acknowledged
      for (int i = 0; i < N; i++) begin
        if (bus.ACK[i] || !bus.REQ[i]) begin
          bus.REQ[i] = ($urandom_range(0, 3) != 0);
          bus.WR_ADDR[5*i +: 5] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(28, 31))
                                                              : 5'($urandom_range(0, 31));
          bus.WR_CHAR[8*i +: 8] = 8'($urandom_range(33, 126));
        end
      end
    end
    bus.REQ = '0;
    bus.CLEAR_REQ = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_clear();
    test_reset_mid_clear();
    test_same_cell();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
